// File: rtl/retire_trace_unit.sv
// Retirement trace monitor: captures writeback/memory/halt activity
// into a record FIFO and keeps saturating instruction/cycle counts.
module retire_trace_unit #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CYCLE_MAX = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic [3:0]  wb_dstreg,
    input  logic [15:0] wb_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        hlt,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [3:0]  rec_flags,
    output logic [3:0]  rec_reg,
    output logic [15:0] rec_regdata,
    output logic [15:0] rec_addr,
    output logic [15:0] rec_memdata,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count,
    output logic        done,
    output logic        overflow,
    output logic        timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 56;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [RW-1:0]     r_mem [DEPTH];
    logic [31:0]       r_inst;
    logic [31:0]       r_cycle;
    logic              r_ovf;
    logic              r_tout;

    logic              w_empty;
    logic              w_full;
    logic              w_run;
    logic              w_event;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_inst_ev;
    logic              w_wdog;
    logic [31:0]       w_cyc_inc;
    logic [RW-1:0]     w_rec;
    logic [RW-1:0]     w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_run   = (r_state == S_RUN);
    assign w_event = w_run & (wb_regwrite | mem_read | mem_write | hlt);
    assign w_pop   = ~w_empty & rec_ready;
    // a full FIFO still accepts a record when the head leaves on the same edge
    assign w_push  = w_event & (~w_full | w_pop);
    assign w_drop  = w_event & w_full & ~w_pop;

    assign w_inst_ev = hlt | wb_regwrite | mem_write;
    assign w_cyc_inc = (r_cycle == CNT_MAX) ? r_cycle : r_cycle + 32'd1;
    assign w_wdog    = (w_cyc_inc >= 32'(CYCLE_MAX));

    assign w_rec = {hlt, mem_write, mem_read, wb_regwrite,
                    wb_dstreg, wb_wdata, mem_addr,
                    mem_write ? mem_wdata : mem_rdata};

    assign w_head = r_mem[r_rptr[AW-1:0]];

    assign rec_valid   = ~w_empty;
    assign rec_flags   = rec_valid ? w_head[55:52] : 4'd0;
    assign rec_reg     = rec_valid ? w_head[51:48] : 4'd0;
    assign rec_regdata = rec_valid ? w_head[47:32] : 16'd0;
    assign rec_addr    = rec_valid ? w_head[31:16] : 16'd0;
    assign rec_memdata = rec_valid ? w_head[15:0]  : 16'd0;
    assign inst_count  = r_inst;
    assign cycle_count = r_cycle;
    assign done        = (r_state == S_DONE);
    assign overflow    = r_ovf;
    assign timeout     = r_tout;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state: halt beats the watchdog on the same edge
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_RUN: begin
                if (hlt) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_wdog) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_FAULT: w_state_nxt = S_FAULT;
        endcase
    end

    // FIFO pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // FIFO storage, contents are meaningless until a pointer covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_rec;
        end
    end

    // saturating counters, live only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst  <= '0;
            r_cycle <= '0;
        end else if (w_run) begin
            r_cycle <= w_cyc_inc;
            if (w_inst_ev && r_inst != CNT_MAX) begin
                r_inst <= r_inst + 32'd1;
            end
        end
    end

    // sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf  <= 1'b0;
            r_tout <= 1'b0;
        end else begin
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_run && !hlt && w_wdog) begin
                r_tout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_retire_trace_unit.sv
// Self-checking bench for retire_trace_unit: vector table, directed
// corner sequences and a queue-based reference model under random input.
module tb_retire_trace_unit;

    localparam int DEPTH = 8;
    localparam int CMAX  = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_regwrite = 1'b0;
    logic [3:0]  wb_dstreg = '0;
    logic [15:0] wb_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        hlt = 1'b0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    logic [3:0]  rec_flags;
    logic [3:0]  rec_reg;
    logic [15:0] rec_regdata;
    logic [15:0] rec_addr;
    logic [15:0] rec_memdata;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic        done;
    logic        overflow;
    logic        timeout;

    retire_trace_unit #(.DEPTH(DEPTH), .CYCLE_MAX(CMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_regwrite(wb_regwrite), .wb_dstreg(wb_dstreg),
        .wb_wdata(wb_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hlt(hlt), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_flags(rec_flags), .rec_reg(rec_reg),
        .rec_regdata(rec_regdata), .rec_addr(rec_addr),
        .rec_memdata(rec_memdata), .inst_count(inst_count),
        .cycle_count(cycle_count), .done(done),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        wb_regwrite = 1'b0; wb_dstreg = '0; wb_wdata = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0;
        mem_wdata = '0; mem_rdata = '0; hlt = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  flags;
        logic [3:0]  rg;
        logic [15:0] regdata;
        logic [15:0] addr;
        logic [15:0] memdata;
    } rec_t;

    rec_t        mq[$];
    logic [31:0] m_inst, m_cyc;
    logic        m_ovf, m_to;
    int          m_mode; // 0 run, 1 drain, 2 done, 3 fault

    task automatic model_reset();
        mq.delete();
        m_inst = 0; m_cyc = 0; m_ovf = 0; m_to = 0; m_mode = 0;
    endtask

    // evaluated with the inputs about to be sampled on the next edge
    task automatic model_step();
        bit   empty0;
        rec_t r;
        empty0 = (mq.size() == 0);
        if (!empty0 && rec_ready) void'(mq.pop_front());
        if (m_mode == 0) begin
            if (wb_regwrite || mem_read || mem_write || hlt) begin
                r.flags   = {hlt, mem_write, mem_read, wb_regwrite};
                r.rg      = wb_dstreg;
                r.regdata = wb_wdata;
                r.addr    = mem_addr;
                r.memdata = mem_write ? mem_wdata : mem_rdata;
                if (mq.size() < DEPTH) mq.push_back(r);
                else m_ovf = 1;
            end
            if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if ((hlt || wb_regwrite || mem_write) && m_inst != 32'hFFFF_FFFF)
                m_inst = m_inst + 1;
            if (hlt) m_mode = 1;
            else if (m_cyc >= CMAX) begin
                m_mode = 3;
                m_to = 1;
            end
        end else if (m_mode == 1) begin
            if (empty0) m_mode = 2;
        end
    endtask

    task automatic model_check();
        chk("m_valid", 32'(rec_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_flags", 32'(rec_flags), 32'(mq[0].flags));
            chk("m_reg", 32'(rec_reg), 32'(mq[0].rg));
            chk("m_regdata", 32'(rec_regdata), 32'(mq[0].regdata));
            chk("m_addr", 32'(rec_addr), 32'(mq[0].addr));
            chk("m_memdata", 32'(rec_memdata), 32'(mq[0].memdata));
        end
        chk("m_inst", inst_count, m_inst);
        chk("m_cycle", cycle_count, m_cyc);
        chk("m_done", 32'(done), 32'(m_mode == 2));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_tout", 32'(timeout), 32'(m_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_in();
        rec_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       nm;
        logic        rw, mr, mw, h;
        logic [3:0]  dst;
        logic [15:0] wd, addr, mwd, mrd;
        logic        e_valid;
        logic [3:0]  e_flags;
        logic [15:0] e_memdata;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n;
        logic [15:0] last;

        vt[0] = '{"regwr", 1,0,0,0, 4'd3, 16'h1234, 16'h0000, 16'h0000,
                  16'h5555, 1, 4'b0001, 16'h5555, 1};
        vt[1] = '{"load", 1,1,0,0, 4'd5, 16'hBEEF, 16'h0040, 16'h0000,
                  16'hBEEF, 1, 4'b0011, 16'hBEEF, 1};
        vt[2] = '{"store", 0,0,1,0, 4'd0, 16'h0000, 16'h0080, 16'hCAFE,
                  16'h1111, 1, 4'b0100, 16'hCAFE, 1};
        vt[3] = '{"rdonly", 0,1,0,0, 4'd0, 16'h0000, 16'h0010, 16'h0000,
                  16'h2222, 1, 4'b0010, 16'h2222, 0};
        vt[4] = '{"halt", 0,0,0,1, 4'd7, 16'h7777, 16'h0030, 16'h4444,
                  16'h3333, 1, 4'b1000, 16'h3333, 1};
        vt[5] = '{"idle", 0,0,0,0, 4'd9, 16'h9999, 16'h0050, 16'h6666,
                  16'h8888, 0, 4'b0000, 16'h0000, 0};
        vt[6] = '{"st_rw", 1,0,1,0, 4'd2, 16'hAAAA, 16'h0060, 16'hD00D,
                  16'hEEEE, 1, 4'b0101, 16'hD00D, 1};

        // reset state
        do_reset();
        chk("rst_valid", 32'(rec_valid), 0);
        chk("rst_flags", 32'(rec_flags), 0);
        chk("rst_memdata", 32'(rec_memdata), 0);
        chk("rst_inst", inst_count, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_tout", 32'(timeout), 0);

        // single-capture vectors
        for (int i = 0; i < 7; i++) begin
            do_reset();
            wb_regwrite = vt[i].rw; mem_read = vt[i].mr;
            mem_write = vt[i].mw; hlt = vt[i].h;
            wb_dstreg = vt[i].dst; wb_wdata = vt[i].wd;
            mem_addr = vt[i].addr; mem_wdata = vt[i].mwd;
            mem_rdata = vt[i].mrd;
            tick();
            clr_in();
            chk({vt[i].nm, "_valid"}, 32'(rec_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk({vt[i].nm, "_flags"}, 32'(rec_flags), 32'(vt[i].e_flags));
                chk({vt[i].nm, "_reg"}, 32'(rec_reg), 32'(vt[i].dst));
                chk({vt[i].nm, "_regdata"}, 32'(rec_regdata), 32'(vt[i].wd));
                chk({vt[i].nm, "_addr"}, 32'(rec_addr), 32'(vt[i].addr));
                chk({vt[i].nm, "_memdata"}, 32'(rec_memdata),
                    32'(vt[i].e_memdata));
            end
            chk({vt[i].nm, "_inst"}, inst_count, vt[i].e_inst);
            chk({vt[i].nm, "_cycle"}, cycle_count, 1);
            chk({vt[i].nm, "_done"}, 32'(done), 0);
            // only one record was produced
            rec_ready = 1'b1;
            tick();
            chk({vt[i].nm, "_single"}, 32'(rec_valid), 0);
        end

        // overflow: 9 stores into 8 entries, then drain in order
        do_reset();
        for (int i = 0; i < 9; i++) begin
            mem_write = 1'b1; mem_addr = 16'(i); mem_wdata = 16'(16'h100 + i);
            tick();
            chk("ovf_flag_step", 32'(overflow), 32'(i == 8));
        end
        clr_in();
        chk("ovf_inst", inst_count, 9);
        chk("ovf_cycle", cycle_count, 9);
        rec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_dvalid", 32'(rec_valid), 1);
            chk("ovf_daddr", 32'(rec_addr), 32'(i));
            chk("ovf_ddata", 32'(rec_memdata), 32'(16'h100 + i));
            tick();
        end
        chk("ovf_empty", 32'(rec_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // full with simultaneous pop and push
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mem_write = 1'b1; mem_addr = 16'(16'h200 + i);
            tick();
        end
        mem_addr = 16'h208;
        rec_ready = 1'b1;
        tick();
        clr_in();
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_head", 32'(rec_addr), 32'h201);
        n = 0;
        last = '0;
        while (rec_valid && n < 20) begin
            last = rec_addr;
            n++;
            tick();
        end
        chk("pp_count", 32'(n), 8);
        chk("pp_last", 32'(last), 32'h208);
        chk("pp_ovf_end", 32'(overflow), 0);

        // halt and drain
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wb_regwrite = 1'b1; wb_dstreg = 4'(i); wb_wdata = 16'(i * 16'h11);
            tick();
        end
        clr_in();
        hlt = 1'b1;
        tick();
        clr_in();
        chk("hd_done0", 32'(done), 0);
        chk("hd_cycle", cycle_count, 4);
        chk("hd_inst", inst_count, 4);
        wb_regwrite = 1'b1; mem_write = 1'b1; mem_read = 1'b1;
        tick();
        tick();
        clr_in();
        chk("hd_frz_cycle", cycle_count, 4);
        chk("hd_frz_inst", inst_count, 4);
        chk("hd_done1", 32'(done), 0);
        rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("hd_valid", 32'(rec_valid), 1);
            chk("hd_flags", 32'(rec_flags), (i < 3) ? 32'h1 : 32'h8);
            if (i < 3) chk("hd_reg", 32'(rec_reg), 32'(i + 1));
            tick();
        end
        chk("hd_empty", 32'(rec_valid), 0);
        chk("hd_done_lag", 32'(done), 0);
        tick();
        chk("hd_done", 32'(done), 1);
        chk("hd_end_cycle", cycle_count, 4);
        chk("hd_end_inst", inst_count, 4);

        // watchdog, inputs ignored in FAULT, async reset clears
        do_reset();
        repeat (CMAX - 1) tick();
        chk("wd_pre_tout", 32'(timeout), 0);
        chk("wd_pre_cycle", cycle_count, CMAX - 1);
        tick();
        chk("wd_tout", 32'(timeout), 1);
        chk("wd_cycle", cycle_count, CMAX);
        wb_regwrite = 1'b1; hlt = 1'b1; rec_ready = 1'b1;
        repeat (3) tick();
        chk("wd_frz_cycle", cycle_count, CMAX);
        chk("wd_frz_inst", inst_count, 0);
        chk("wd_norec", 32'(rec_valid), 0);
        chk("wd_nodone", 32'(done), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tout", 32'(timeout), 0);
        chk("ar_cycle", cycle_count, 0);
        chk("ar_inst", inst_count, 0);
        chk("ar_ovf", 32'(overflow), 0);

        // halt and watchdog on the same edge: halt wins
        do_reset();
        repeat (CMAX - 1) tick();
        hlt = 1'b1;
        tick();
        clr_in();
        chk("hw_tout", 32'(timeout), 0);
        chk("hw_cycle", cycle_count, CMAX);
        chk("hw_flags", 32'(rec_flags), 32'h8);
        rec_ready = 1'b1;
        tick();
        chk("hw_done_lag", 32'(done), 0);
        tick();
        chk("hw_done", 32'(done), 1);

        // random traffic against the reference model
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 60; c++) begin
                int op;
                op = int'($urandom_range(0, 3));
                wb_regwrite = (op == 1) || (op == 3 && $urandom_range(0, 1) == 1);
                mem_read    = (op == 1);
                mem_write   = (op == 2);
                wb_dstreg   = 4'($urandom);
                wb_wdata    = 16'($urandom);
                mem_addr    = 16'($urandom);
                mem_wdata   = 16'($urandom);
                mem_rdata   = 16'($urandom);
                hlt         = ($urandom_range(0, 29) == 0);
                if (ep % 3 == 0) rec_ready = ($urandom_range(0, 5) == 0);
                else rec_ready = ($urandom_range(0, 2) != 0);
                model_step();
                tick();
                model_check();
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
